// File: rtl/usb_sample_player.sv
// usb_sample_player: FIFO-buffered playback of packed 32-bit words as four
// signed 8-bit samples, released at a programmable rate.
// Optional feature macro: USB_PLAYER_STATS_EN enables the underrun/overflow
// counters; when undefined both counter outputs are tied to zero.
module usb_sample_player #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        usb_rd_data,
  input  logic               usb_rd_data_valid,
  output logic               usb_rd_full,
  input  logic               enable,
  input  logic [15:0]        rate_div,
  input  logic               flush,
  output logic [7:0]         sample_out,
  output logic               sample_valid,
  output logic [LEVEL_W-1:0] level,
  output logic [15:0]        underrun_count,
  output logic [15:0]        overflow_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full_q;

  logic [0:0]         state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         sample_q, sample_d;
  logic               valid_q, valid_d;

  logic [15:0]        cnt_q;
  logic               loaded_q;
  logic [15:0]        cnt_cur;

  logic               fifo_empty;
  logic               tick;
  logic               last_byte;
  logic               push;
  logic               pop;

  // Tick generator and FIFO handshake decode
  always_comb begin
    // Until the first clock after reset the counter reads as rate_div, so the
    // async reset never has to load a non-constant value.
    cnt_cur    = loaded_q ? cnt_q : rate_div;
    fifo_empty = (level_q == '0);
    tick       = enable & (cnt_cur == '0);
    last_byte  = (state_q == ST_HOLD) & tick & (idx_q == 2'd3);
    // Fetch from EMPTY is gated by enable so a paused player keeps every
    // buffered word counted in level.
    pop        = ~flush & ~fifo_empty &
                 (((state_q == ST_EMPTY) & enable) | last_byte);
    push       = ~flush & usb_rd_data_valid & ~full_q;
    level_d    = flush ? '0 : level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  end

  // Unpacker next-state: fetch, byte select and sample strobe
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop) begin
            hold_d  = mem_q[rd_ptr_q];
            idx_d   = 2'd0;
            state_d = ST_HOLD;
          end
        end
        default: begin
          if (tick) begin
            sample_d = hold_q[{idx_q, 3'b000} +: 8];
            valid_d  = 1'b1;
            if (idx_q == 2'd3) begin
              if (pop) begin
                hold_d = mem_q[rd_ptr_q];
                idx_d  = 2'd0;
              end else begin
                state_d = ST_EMPTY;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // FIFO storage; contents are discarded by pointer reset, not cleared
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= usb_rd_data;
  end

  // FIFO pointers, level and registered full flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_W'(DEPTH));
    end
  end

  // Sample period countdown; holds the reload value while paused or flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= 1'b1;
      if (flush || !enable || cnt_cur == '0) cnt_q <= rate_div;
      else                                    cnt_q <= cnt_cur - 16'd1;
    end
  end

  // Unpacker state and registered sample outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_EMPTY;
      hold_q   <= '0;
      idx_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign usb_rd_full  = full_q;
  assign level        = level_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

`ifdef USB_PLAYER_STATS_EN
  logic [15:0] underrun_q;
  logic [15:0] overflow_q;
  logic        underrun_ev;
  logic        drop_ev;

  assign underrun_ev = ~flush & tick & (state_q == ST_EMPTY) & fifo_empty;
  assign drop_ev     = ~flush & usb_rd_data_valid & full_q;

  // Saturating event counters, cleared by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_q <= '0;
      overflow_q <= '0;
    end else if (flush) begin
      underrun_q <= '0;
      overflow_q <= '0;
    end else begin
      if (underrun_ev && underrun_q != '1) underrun_q <= underrun_q + 16'd1;
      if (drop_ev && overflow_q != '1)     overflow_q <= overflow_q + 16'd1;
    end
  end

  assign underrun_count = underrun_q;
  assign overflow_count = overflow_q;
`else
  assign underrun_count = '0;
  assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_usb_sample_player.sv
// Testbench for usb_sample_player (DEPTH=4). Honours USB_PLAYER_STATS_EN for
// the expected counter values.
module tb_usb_sample_player;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
`ifdef USB_PLAYER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   usb_rd_data;
  logic          usb_rd_data_valid;
  logic          usb_rd_full;
  logic          enable;
  logic [15:0]   rate_div;
  logic          flush;
  logic [7:0]    sample_out;
  logic          sample_valid;
  logic [LW-1:0] level;
  logic [15:0]   underrun_count;
  logic [15:0]   overflow_count;

  always #5 clk = ~clk;

  usb_sample_player #(.DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .clk               (clk),
    .reset             (reset),
    .usb_rd_data       (usb_rd_data),
    .usb_rd_data_valid (usb_rd_data_valid),
    .usb_rd_full       (usb_rd_full),
    .enable            (enable),
    .rate_div          (rate_div),
    .flush             (flush),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .level             (level),
    .underrun_count    (underrun_count),
    .overflow_count    (overflow_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word queue, current word with byte position, countdown
  logic [31:0] mq[$];
  bit          m_have;
  logic [31:0] m_cur;
  int          m_idx;
  int          m_cnt;
  logic [7:0]  m_so;
  bit          m_sv;
  bit          m_full;
  int          m_under;
  int          m_over;

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int exp_stat(int v);
    return STATS ? v : 0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_have  = 1'b0;
    m_idx   = 0;
    m_cnt   = int'(rate_div);
    m_so    = 8'h00;
    m_sv    = 1'b0;
    m_full  = 1'b0;
    m_under = 0;
    m_over  = 0;
  endfunction

  function automatic void model_clock();
    bit tick;
    tick = enable && (m_cnt == 0);
    if (flush) begin
      mq.delete();
      m_have = 1'b0; m_sv = 1'b0; m_full = 1'b0;
      m_under = 0; m_over = 0;
      m_cnt = int'(rate_div);
      return;
    end
    m_sv = 1'b0;
    if (!m_have) begin
      if (tick && mq.size() == 0) m_under = sat16(m_under + 1);
      if (enable && mq.size() > 0) begin
        m_cur = mq.pop_front(); m_have = 1'b1; m_idx = 0;
      end
    end else if (tick) begin
      m_so = m_cur[8*m_idx +: 8];
      m_sv = 1'b1;
      if (m_idx == 3) begin
        if (mq.size() > 0) begin m_cur = mq.pop_front(); m_idx = 0; end
        else m_have = 1'b0;
      end else begin
        m_idx++;
      end
    end
    if (usb_rd_data_valid) begin
      if (m_full) m_over = sat16(m_over + 1);
      else        mq.push_back(usb_rd_data);
    end
    m_full = (mq.size() == DEPTH);
    if (!enable || m_cnt == 0) m_cnt = int'(rate_div);
    else                       m_cnt--;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_clock();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; usb_rd_data = '0; usb_rd_data_valid = 1'b0;
    enable = 1'b0; rate_div = 16'd0; flush = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL reset_sample_out got %0h exp 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %0b exp 0", sample_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (usb_rd_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", usb_rd_full); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_underrun got %0d exp 0", underrun_count); end
    checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow_count); end
    #3 reset = 1'b1;
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [7:0]  exp_so;
    bit          exp_sv;
    w = 32'h807F01FF;
    enable = 1'b1; rate_div = 16'd0;
    usb_rd_data = w; usb_rd_data_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      usb_rd_data_valid = 1'b0;
      exp_sv = (k >= 2 && k <= 5);
      exp_so = (k < 2) ? 8'h00 : w[8*((k - 2 > 3) ? 3 : k - 2) +: 8];
      checks++; if (sample_valid !== exp_sv) begin errors++; $display("FAIL single_valid k=%0d got %0b exp %0b", k, sample_valid, exp_sv); end
      checks++; if (sample_out !== exp_so) begin errors++; $display("FAIL single_out k=%0d got %0h exp %0h", k, sample_out, exp_so); end
      if (k == 0) begin
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
      end
    end
  endtask

  task automatic test_rate();
    logic [7:0] exp_b[$];
    logic [31:0] w;
    int n_sv, prev, last;
    enable = 1'b0; rate_div = 16'd9; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom();
      for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
      usb_rd_data = w; usb_rd_data_valid = 1'b1;
      step();
    end
    usb_rd_data_valid = 1'b0; enable = 1'b1;
    n_sv = 0; prev = -1; last = -1;
    for (int c = 0; c < 200 && n_sv < 8; c++) begin
      step();
      if (sample_valid) begin
        n_sv++;
        checks++;
        if (exp_b.size() == 0 || sample_out !== exp_b[0]) begin
          errors++; $display("FAIL rate_byte n=%0d got %0h", n_sv, sample_out);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
        if (prev >= 0) begin
          checks++; if (c - prev != 10) begin errors++; $display("FAIL rate_spacing got %0d exp 10", c - prev); end
        end
        prev = c;
      end
    end
    checks++; if (n_sv != 8) begin errors++; $display("FAIL rate_count got %0d exp 8", n_sv); end
    for (int c = 0; c < 35; c++) begin
      step();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rate_extra_valid c=%0d got 1 exp 0", c); end
    end
    checks++; if (underrun_count !== 16'(exp_stat(3))) begin errors++; $display("FAIL rate_underrun got %0d exp %0d", underrun_count, exp_stat(3)); end
    checks++; if (underrun_count !== 16'(exp_stat(m_under))) begin errors++; $display("FAIL rate_underrun_model got %0d exp %0d", underrun_count, exp_stat(m_under)); end
  endtask

  task automatic test_overflow();
    logic [31:0] words[6];
    logic [7:0]  exp_b[$];
    int n_sv;
    enable = 1'b0; rate_div = 16'd0; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      words[i] = $urandom();
      if (i < 4) for (int b = 0; b < 4; b++) exp_b.push_back(words[i][8*b +: 8]);
      usb_rd_data = words[i]; usb_rd_data_valid = 1'b1;
      step();
      if (i == 3) begin
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
        checks++; if (usb_rd_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b exp 1", usb_rd_full); end
      end
    end
    usb_rd_data_valid = 1'b0;
    checks++; if (overflow_count !== 16'(exp_stat(2))) begin errors++; $display("FAIL ovf_count got %0d exp %0d", overflow_count, exp_stat(2)); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level_after got %0d exp 4", level); end
    enable = 1'b1;
    n_sv = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (sample_valid) begin
        n_sv++;
        checks++;
        if (exp_b.size() == 0 || sample_out !== exp_b[0]) begin
          errors++; $display("FAIL ovf_byte n=%0d got %0h", n_sv, sample_out);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
      end
    end
    checks++; if (n_sv != 16) begin errors++; $display("FAIL ovf_samples got %0d exp 16", n_sv); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[$];
    logic [31:0] w;
    int sent, n_sv, first, last, idle, max_under;
    enable = 1'b0; rate_div = 16'd0; flush = 1'b1;
    step();
    flush = 1'b0;
    sent = 0; n_sv = 0; first = -1; last = -1; idle = 0; max_under = 0;
    for (int c = 0; c < 600 && idle < 20; c++) begin
      if (c == 2) enable = 1'b1;
      if (sent < 64 && !m_full) begin
        w = $urandom();
        for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
        usb_rd_data = w; usb_rd_data_valid = 1'b1; sent++;
      end else begin
        usb_rd_data_valid = 1'b0;
      end
      step();
      if (sample_valid) begin
        n_sv++;
        if (first < 0) first = c;
        last = c;
        if (int'(underrun_count) > max_under) max_under = int'(underrun_count);
        checks++;
        if (exp_b.size() == 0 || sample_out !== exp_b[0]) begin
          errors++; $display("FAIL b2b_byte n=%0d got %0h", n_sv, sample_out);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
      end else if (sent == 64) begin
        idle++;
      end
    end
    usb_rd_data_valid = 1'b0;
    checks++; if (n_sv != 256) begin errors++; $display("FAIL b2b_count got %0d exp 256", n_sv); end
    checks++; if (last - first + 1 != n_sv) begin errors++; $display("FAIL b2b_gaps span %0d samples %0d", last - first + 1, n_sv); end
    checks++; if (max_under != 0) begin errors++; $display("FAIL b2b_underrun got %0d exp 0", max_under); end
    checks++; if (underrun_count !== 16'(exp_stat(m_under))) begin errors++; $display("FAIL b2b_underrun_end got %0d exp %0d", underrun_count, exp_stat(m_under)); end
  endtask

  task automatic test_flush();
    enable = 1'b0; rate_div = 16'd0;
    for (int i = 0; i < 3; i++) begin
      usb_rd_data = $urandom(); usb_rd_data_valid = 1'b1;
      step();
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got %0d exp 3", level); end
    usb_rd_data = $urandom(); usb_rd_data_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; usb_rd_data_valid = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    checks++; if (usb_rd_full !== 1'b0) begin errors++; $display("FAIL flush_full got %0b exp 0", usb_rd_full); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL flush_underrun got %0d exp 0", underrun_count); end
    checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL flush_overflow got %0d exp 0", overflow_count); end
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL flush_valid c=%0d got 1 exp 0", c); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level_after got %0d exp 0", level); end
    checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL flush_overflow_after got %0d exp 0", overflow_count); end
    checks++; if (underrun_count !== 16'(exp_stat(m_under))) begin errors++; $display("FAIL flush_underrun_after got %0d exp %0d", underrun_count, exp_stat(m_under)); end
  endtask

  task automatic test_reset_midplay();
    int n_sv;
    enable = 1'b0; rate_div = 16'($urandom_range(1, 3)); flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      usb_rd_data = $urandom(); usb_rd_data_valid = 1'b1;
      step();
    end
    usb_rd_data_valid = 1'b0; enable = 1'b1;
    n_sv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (sample_valid) n_sv++;
      checks++; if (sample_valid !== m_sv || (m_sv && sample_out !== m_so)) begin
        errors++; $display("FAIL midplay_model c=%0d got %0b/%0h exp %0b/%0h", c, sample_valid, sample_out, m_sv, m_so);
      end
    end
    checks++; if (n_sv == 0) begin errors++; $display("FAIL midplay_started got 0 samples exp >0"); end
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL async_sample_out got %0h exp 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL async_sample_valid got %0b exp 0", sample_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL async_level got %0d exp 0", level); end
    checks++; if (usb_rd_full !== 1'b0) begin errors++; $display("FAIL async_full got %0b exp 0", usb_rd_full); end
    checks++; if (underrun_count !== 16'd0 || overflow_count !== 16'd0) begin
      errors++; $display("FAIL async_counters got %0d/%0d exp 0/0", underrun_count, overflow_count);
    end
    repeat (2) step();
    #3 reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      checks++; if (sample_valid !== 1'b0 || level !== '0) begin
        errors++; $display("FAIL post_reset c=%0d valid %0b level %0d exp 0/0", c, sample_valid, level);
      end
    end
    checks++; if (underrun_count !== 16'(exp_stat(m_under))) begin errors++; $display("FAIL post_reset_underrun got %0d exp %0d", underrun_count, exp_stat(m_under)); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_rate();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_midplay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
